vc_queue: RTL
=============

Name: vc_queue

Overview:
- Parametrised successor to the single-channel mesh queue: NUM_CH independent per-channel FIFOs (virtual channels) behind one shared input port and one shared output port.
- Input side: one flit per cycle, tagged with a channel id; per-channel backpressure.
- Output side: round-robin arbitration across non-empty channels, valid/ready handshake, grant held stable while stalled.
- Sits between a router input port and the crossbar in the mesh.

Parameters:
- WIDTH, 32, flit width in bits.
- DEPTH, 4, entries per channel; any value >= 2, need not be a power of two.
- NUM_CH, 2, number of channels; >= 1.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  flit present on in_data.
- in_ch  in  CH_W  target channel; CH_W = max(1, $clog2(NUM_CH)).
- in_data  in  WIDTH  flit.
- in_ready  out  NUM_CH  per-channel not-full; bit c = (count[c] != DEPTH).
- out_valid  out  1  at least one channel non-empty.
- out_ch  out  CH_W  granted channel; 0 when out_valid = 0.
- out_data  out  WIDTH  head of granted channel; all-zero when out_valid = 0.
- out_ready  in  1  consumer accepts out_data this cycle.

Behaviour:
- Reset (async assert, sync-safe deassert): all read/write pointers 0, all counts 0, rr_ptr 0, lock 0.
  - Outputs after reset: in_ready all-ones, out_valid 0, out_ch 0, out_data 0.
  - Storage is not reset.
- Push: when in_valid && in_ready[in_ch], write in_data at wr_ptr[in_ch], then wr_ptr increments, wrapping DEPTH-1 -> 0.
  - in_valid with in_ready[in_ch] = 0: flit is dropped silently; the sender must respect in_ready.
  - in_ch >= NUM_CH: the push is ignored.
- Pop: on out_valid && out_ready, rd_ptr[out_ch] increments (same wrap rule).
- Count: count[c] += push_c - pop_c; push and pop on the same channel in the same cycle leaves count unchanged.
- in_ready uses registered count only; a full channel does not accept a push even if popped in the same cycle.
- Latency: a pushed flit is visible on out_data at the earliest 1 cycle after the push edge. No same-cycle bypass.
- Ordering: FIFO order within each channel; no ordering guarantee between channels.
- Arbiter, combinational grant:
  - Grant = first non-empty channel at or after rr_ptr, searching cyclically.
  - On a handshake, rr_ptr <= (grant + 1) mod NUM_CH.
- Lock FSM, states IDLE/LOCKED:
  - IDLE -> LOCKED when out_valid && !out_ready; the current grant is stored in lock_ch.
  - While LOCKED, grant = lock_ch regardless of pushes to other channels, so out_ch and out_data stay stable.
  - LOCKED -> IDLE on handshake.
  - The locked channel cannot empty without a pop, so LOCKED always implies out_valid = 1.
- NUM_CH = 1: arbiter degenerates; out_ch is constant 0.
- Reset mid-operation: all contents are discarded and all state returns to the reset values above.

Optional Feature:
- Macro: VCQ_OCCUPANCY_EN.
- Defined: adds output port occupancy, out, NUM_CH*CNT_W bits, CNT_W = $clog2(DEPTH+1).
  - Slice c = registered count[c].
  - Reset value 0; updates on the same edge as the pointers.
- Undefined: the port and any logic feeding it are absent; all other behaviour is identical.

Decomposition:
- Shared package vc_queue_pkg holds:
  - Width helper functions for CH_W and CNT_W.
  - The lock-state enum (IDLE, LOCKED).
  - The DEPTH/NUM_CH range checks, used as elaboration-time assertions.
- One natural sub-module, ch_fifo, instantiated NUM_CH times:
  - Single-channel storage, pointers and count.
  - Ports: push, pop, data in, head out, full, empty, count.
- Arbiter and lock FSM live in vc_queue.

Test Plan:
- Reset then idle (NUM_CH=2, DEPTH=4): in_ready=2'b11, out_valid=0, out_data=0; assert rst mid-traffic -> same values within the same cycle.
- Fill ch0 with 0x11,0x22,0x33,0x44 with out_ready=0: in_ready[0]=0 after the 4th push; 5th push 0x55 is dropped; draining yields 0x11..0x44 in order, then out_valid=0.
- Wrap: DEPTH=3; push/pop 7 flits 0xA0..0xA6 through ch1 with interleaved push+pop cycles -> all 7 delivered in order; count never exceeds 3.
- Round-robin: ch0 and ch1 each hold 3 flits, out_ready=1 -> out_ch sequence 0,1,0,1,0,1.
- Lock: ch1 holds 0xB1, out_ready=0, rr_ptr=1; push 0xC0 to ch0 -> out_ch stays 1 and out_data 0xB1 until out_ready=1; next grant is ch0 with 0xC0.
- VCQ_OCCUPANCY_EN defined: push 2 flits to ch1, pop 1 -> occupancy slice 1 reads 1, 2, 1 on successive edges; slice 0 stays 0.

Source files
------------

// File: rtl/vc_queue_pkg.sv
// Shared types, width helpers and parameter range checks for the virtual-channel queue.
package vc_queue_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    function automatic int ch_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w(input int d);
        return $clog2(d + 1);
    endfunction

    function automatic int ptr_w(input int d);
        return (d > 1) ? $clog2(d) : 1;
    endfunction

    function automatic bit depth_ok(input int d);
        return d >= 2;
    endfunction

    function automatic bit num_ch_ok(input int n);
        return n >= 1;
    endfunction

endpackage

// File: rtl/vc_queue_if.sv
// Shared input/output port bundle of the VC queue; master drives flits in, slave is the queue.
interface vc_queue_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2
);
    localparam int CH_W = vc_queue_pkg::ch_w(NUM_CH);

    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [WIDTH-1:0]  in_data;
    logic [NUM_CH-1:0] in_ready;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;

    modport master (
        output in_valid, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data
    );

    modport slave (
        input  in_valid, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data
    );

endinterface

// File: rtl/vc_queue_ch_fifo.sv
// Single-channel circular FIFO: storage, pointers and occupancy count.
// The caller guarantees push only when not full and pop only when not empty.
module ch_fifo
    import vc_queue_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push_i,
    input  logic                      pop_i,
    input  logic [WIDTH-1:0]          data_i,
    output logic [WIDTH-1:0]          head_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o
);
    localparam int CNT_W = cnt_w(DEPTH);
    localparam int PTR_W = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wr_d  = push_i ? next_ptr(wr_q) : wr_q;
        rd_d  = pop_i  ? next_ptr(rd_q) : rd_q;
        cnt_d = cnt_q;
        case ({push_i, pop_i})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q] <= data_i;
    end

    assign head_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CNT_W'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;

endmodule

// File: rtl/vc_queue.sv
// Virtual-channel queue: NUM_CH FIFOs behind one input, round-robin output with grant lock.
// Optional occupancy output enabled by defining VCQ_OCCUPANCY_EN.
module vc_queue
    import vc_queue_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 4,
    parameter int NUM_CH = 2
) (
    input  logic clk,
    input  logic rst,
    vc_queue_if.slave q
`ifdef VCQ_OCCUPANCY_EN
    ,
    output logic [NUM_CH*cnt_w(DEPTH)-1:0] occupancy
`endif
);
    localparam int CH_W  = ch_w(NUM_CH);
    localparam int CNT_W = cnt_w(DEPTH);

    if (!depth_ok(DEPTH)) begin : g_bad_depth
        $error("vc_queue: DEPTH must be >= 2");
    end
    if (!num_ch_ok(NUM_CH)) begin : g_bad_num_ch
        $error("vc_queue: NUM_CH must be >= 1");
    end

    logic [NUM_CH-1:0]             push, pop, full, empty, in_ready;
    logic [NUM_CH-1:0][WIDTH-1:0]  head;
    logic [NUM_CH-1:0][CNT_W-1:0]  cnt;

    lock_state_e     state_q, state_d;
    logic [CH_W-1:0] lock_ch_q, lock_ch_d;
    logic [CH_W-1:0] rr_q, rr_d;
    logic [CH_W-1:0] arb_gnt, grant;
    logic            out_valid, hs;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        // Out-of-range in_ch matches no channel, so the push is ignored.
        assign push[c]     = q.in_valid && (q.in_ch == CH_W'(c)) && !full[c];
        assign pop[c]      = hs && (grant == CH_W'(c));
        assign in_ready[c] = (cnt[c] != CNT_W'(DEPTH));

        ch_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (push[c]),
            .pop_i   (pop[c]),
            .data_i  (q.in_data),
            .head_o  (head[c]),
            .full_o  (full[c]),
            .empty_o (empty[c]),
            .count_o (cnt[c])
        );

`ifdef VCQ_OCCUPANCY_EN
        assign occupancy[c*CNT_W +: CNT_W] = cnt[c];
`endif
    end

    // Cyclic search for the first non-empty channel starting at rr_q.
    always_comb begin
        int   idx;
        logic found;
        arb_gnt = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (!found && !empty[idx]) begin
                arb_gnt = CH_W'(idx);
                found   = 1'b1;
            end
        end
    end

    assign grant     = (state_q == LOCKED) ? lock_ch_q : arb_gnt;
    assign out_valid = ~&empty;
    assign hs        = out_valid && q.out_ready;

    assign q.in_ready  = in_ready;
    assign q.out_valid = out_valid;
    assign q.out_ch    = out_valid ? grant : '0;
    assign q.out_data  = out_valid ? head[grant] : '0;

    always_comb begin
        state_d   = state_q;
        lock_ch_d = lock_ch_q;
        rr_d      = rr_q;
        case (state_q)
            IDLE: begin
                if (out_valid && !q.out_ready) begin
                    state_d   = LOCKED;
                    lock_ch_d = grant;
                end
            end
            LOCKED: begin
                if (hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (hs) rr_d = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            lock_ch_q <= lock_ch_d;
            rr_q      <= rr_d;
        end
    end

endmodule
